// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Shared constants and types for the note pattern loader.
//               - NOTE_ADDR_W / NOTE_DATA_W / NOTE_DEPTH : default geometry
//               - NOTE_CHK_SEED : initial value of the frame checksum
//               - loader_state_e : loader FSM state encoding
//               Optional feature macro: NOTE_LOADER_CHECKSUM_EN (adds S_CHK).
// Revision    : 1.0  initial release
// ============================================================================
package note_pkg;

    localparam int NOTE_ADDR_W = 5;
    localparam int NOTE_DATA_W = 16;
    localparam int NOTE_DEPTH  = 32;

    // Checksum accumulator start value; the host folds the same seed into its
    // XOR so that an all-zero frame does not produce an all-zero check byte.
    localparam logic [7:0] NOTE_CHK_SEED = 8'h27;

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
`ifdef NOTE_LOADER_CHECKSUM_EN
        S_CHK  = 3'd5,
`endif
        S_DONE = 3'd4
    } loader_state_e;

endpackage : note_pkg
`default_nettype wire

// File: rtl/note_pattern_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : note_pattern_loader_if
// Description : Byte stream, RAM write port and sequencer update bundle of
//               the note pattern loader.
//               slave  : the loader (consumes bytes, drives RAM/sequencer)
//               master : the host side (drives bytes, observes the rest)
//               Signals: i_byte, i_byte_valid, o_byte_ready, o_wr_en,
//               o_wr_addr, o_wr_data, o_new_addr, o_new_pattern_len,
//               o_new_addr_valid, o_busy, o_err
// Revision    : 1.0  initial release
// ============================================================================
interface note_pattern_loader_if #(
    parameter int ADDR_W = note_pkg::NOTE_ADDR_W,
    parameter int DATA_W = note_pkg::NOTE_DATA_W
);
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic [ADDR_W-1:0] o_new_addr;
    logic [ADDR_W-1:0] o_new_pattern_len;
    logic              o_new_addr_valid;
    logic              o_busy;
    logic              o_err;

    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_new_addr, o_new_pattern_len, o_new_addr_valid, o_busy, o_err
    );

    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_new_addr, o_new_pattern_len, o_new_addr_valid, o_busy, o_err
    );
endinterface : note_pattern_loader_if
`default_nettype wire

// File: rtl/note_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : note_word_assembler
// Description : Pairs HI/LO stream bytes into note words and numbers them.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_byte         : current stream byte
//   i_clear        : restart word numbering (start of payload)
//   i_take_hi      : latch i_byte as the high half
//   i_take_lo      : complete a word with i_byte as the low half
//   o_word         : last completed word {HI,LO}
//   o_word_idx     : index of o_word within the frame
//   o_word_stb     : 1-cycle strobe, cycle after the LO byte
//   o_count        : words completed so far in this frame
// Revision    : 1.0  initial release
// ============================================================================
module note_word_assembler #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_clear,
    input  logic              i_take_hi,
    input  logic              i_take_lo,
    output logic [DATA_W-1:0] o_word,
    output logic [ADDR_W-1:0] o_word_idx,
    output logic              o_word_stb,
    output logic [ADDR_W-1:0] o_count
);
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              word_stb_q, word_stb_d;

    always_comb begin
        hi_d       = hi_q;
        count_d    = count_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        word_stb_d = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end
        if (i_take_hi) begin
            hi_d = i_byte;
        end
        if (i_take_lo) begin
            word_d     = {hi_q, i_byte};
            word_idx_d = count_q;
            count_d    = count_q + 1'b1;
            word_stb_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q       <= '0;
            count_q    <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            word_stb_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            count_q    <= count_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            word_stb_q <= word_stb_d;
        end
    end

    assign o_word     = word_q;
    assign o_word_idx = word_idx_q;
    assign o_word_stb = word_stb_q;
    assign o_count    = count_q;

endmodule : note_word_assembler
`default_nettype wire

// File: rtl/note_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : note_pattern_loader
// Description : Writer side of the note pattern RAM. Parses frames
//               ADDR, LEN, N x {HI,LO} [, CHK], writes the words into the RAM
//               and, for a good frame, hands addr/len to the sequencer.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : note_pattern_loader_if.slave (byte stream in, RAM write port,
//             sequencer update, busy/err status)
//   Optional macro NOTE_LOADER_CHECKSUM_EN: expect an XOR check byte after
//   the last word; a mismatch marks the frame bad.
// Revision    : 1.0  initial release
// ============================================================================
module note_pattern_loader
    import note_pkg::*;
#(
    parameter int ADDR_W = NOTE_ADDR_W,
    parameter int DATA_W = NOTE_DATA_W,
    parameter int DEPTH  = NOTE_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    note_pattern_loader_if.slave  bus
);
    localparam logic [ADDR_W:0] c_depth_lim = (ADDR_W+1)'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              bad_q, bad_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] new_addr_q, new_addr_d;
    logic [ADDR_W-1:0] new_len_q, new_len_d;
    logic              new_valid_q, new_valid_d;
`ifdef NOTE_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              w_take;
    logic              w_clear;
    logic              w_take_hi;
    logic              w_take_lo;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_word_stb;
    logic [ADDR_W-1:0] w_count;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_oob;
    logic              w_drop;

    note_word_assembler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_asm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_byte     (bus.i_byte),
        .i_clear    (w_clear),
        .i_take_hi  (w_take_hi),
        .i_take_lo  (w_take_lo),
        .o_word     (w_word),
        .o_word_idx (w_word_idx),
        .o_word_stb (w_word_stb),
        .o_count    (w_count)
    );

    // Address wraps modulo 2**ADDR_W by width truncation.
    assign w_wr_addr = base_q + w_word_idx;
    assign w_oob     = ({1'b0, w_wr_addr} >= c_depth_lim);
    assign w_drop    = w_word_stb & w_oob;
    assign w_take    = bus.i_byte_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        bad_d       = bad_q | w_drop;
        err_d       = 1'b0;
        new_addr_d  = new_addr_q;
        new_len_d   = new_len_q;
        new_valid_d = 1'b0;
        w_clear     = 1'b0;
        w_take_hi   = 1'b0;
        w_take_lo   = 1'b0;
`ifdef NOTE_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            S_ADDR: begin
                if (w_take) begin
                    base_d  = bus.i_byte[ADDR_W-1:0];
                    bad_d   = 1'b0;
`ifdef NOTE_LOADER_CHECKSUM_EN
                    chk_d   = NOTE_CHK_SEED ^ bus.i_byte;
`endif
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (w_take) begin
                    len_d   = bus.i_byte[ADDR_W-1:0];
                    w_clear = 1'b1;
`ifdef NOTE_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.i_byte;
`endif
                    if (bus.i_byte[ADDR_W-1:0] == '0) begin
                        err_d   = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                w_take_hi = w_take;
                if (w_take) begin
`ifdef NOTE_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.i_byte;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                w_take_lo = w_take;
                if (w_take) begin
`ifdef NOTE_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.i_byte;
`endif
                    // w_count has not yet counted the word completing now.
                    if (w_count + 1'b1 == len_q) begin
`ifdef NOTE_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
`ifdef NOTE_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_take) begin
                    if (bus.i_byte != chk_q) begin
                        bad_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // The last word's strobe can land in this very cycle, so its
                // drop status is folded in directly rather than via bad_q.
                if (bad_q | w_drop) begin
                    err_d = 1'b1;
                end else begin
                    new_valid_d = 1'b1;
                    new_addr_d  = base_q;
                    new_len_d   = len_q;
                end
                state_d = S_ADDR;
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
        ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_ADDR;
            base_q      <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            new_addr_q  <= '0;
            new_len_q   <= '0;
            new_valid_q <= 1'b0;
`ifdef NOTE_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            new_addr_q  <= new_addr_d;
            new_len_q   <= new_len_d;
            new_valid_q <= new_valid_d;
`ifdef NOTE_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign bus.o_byte_ready      = ready_q;
    assign bus.o_wr_en           = w_word_stb & ~w_oob;
    assign bus.o_wr_addr         = w_wr_addr;
    assign bus.o_wr_data         = w_word;
    assign bus.o_new_addr        = new_addr_q;
    assign bus.o_new_pattern_len = new_len_q;
    assign bus.o_new_addr_valid  = new_valid_q;
    assign bus.o_busy            = (state_q != S_ADDR);
    assign bus.o_err             = err_q | w_drop;

endmodule : note_pattern_loader
`default_nettype wire
